// File: rtl/seq_1011_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_1011_pkg
//  Brief    : Shared types and constants for the 1011 serial frame transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package seq_1011_pkg;

    // Frame FSM states; PAR is only reachable when SEQ_TX_PARITY_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_t;

    localparam int         SYNC_W_DEF   = 4;
    localparam logic [3:0] SYNC_PAT_DEF = 4'b1011;

    // Bit counter width: wide enough for max(a,b)-1, never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage : seq_1011_pkg
`default_nettype wire

// File: rtl/seq_1011_tx_piso_shift.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift
//  Brief    : Parallel-load, left-shift register; MSB is the serial output.
//             Load has priority over shift.
//  Revision : 1.0  initial release
// ============================================================================
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sh;

    // Capture a new word on load, otherwise move the next bit up to the MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
            sh <= sh << 1;
        end
    end

    assign msb = sh[W-1];

endmodule : piso_shift
`default_nettype wire

// File: rtl/seq_1011_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_1011_tx
//  Brief    : Serial frame transmitter. Sends SYNC_PAT (MSB first) followed by
//             a DATA_W payload (MSB first) for every word accepted on the
//             valid/ready load port. Back-to-back frames have no gap bit.
//             Optional feature macro: SEQ_TX_PARITY_EN appends one even-parity
//             bit after the payload.
//  Revision : 1.0  initial release
// ============================================================================
module seq_1011_tx
    import seq_1011_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter logic              IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = cnt_width(SYNC_W, DATA_W);
    localparam int PW = 1 << CW;
    // Pattern padded to the full counter range so the counter indexes it directly.
    localparam logic [PW-1:0] PAT_EXT = PW'(SYNC_PAT);

    state_t          state, next_state;
    logic [CW-1:0]   cnt, next_cnt;
    logic            accept;
    logic            last_bit;
    logic            shift_msb;
`ifdef SEQ_TX_PARITY_EN
    logic            parity;
`endif

    assign accept = load_valid & load_ready;

    // Payload shifter: loaded on accept, advanced once per DATA bit.
    piso_shift #(
        .W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (state == ST_DATA),
        .din   (load_data),
        .msb   (shift_msb)
    );

    // State, bit counter and captured parity registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
`ifdef SEQ_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
`ifdef SEQ_TX_PARITY_EN
            if (accept) parity <= ^load_data;
`endif
        end
    end

    // Next-state and counter logic; a frame end chains straight into SYNC on accept.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_SYNC;
                    next_cnt   = CW'(SYNC_W - 1);
                end
            end
            ST_SYNC: begin
                if (cnt == '0) begin
                    next_state = ST_DATA;
                    next_cnt   = CW'(DATA_W - 1);
                end else begin
                    next_cnt = cnt - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt != '0) begin
                    next_cnt = cnt - CW'(1);
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    next_state = ST_PAR;
                    next_cnt   = '0;
`else
                    next_state = accept ? ST_SYNC : ST_IDLE;
                    next_cnt   = accept ? CW'(SYNC_W - 1) : '0;
`endif
                end
            end
            ST_PAR: begin
                next_state = accept ? ST_SYNC : ST_IDLE;
                next_cnt   = accept ? CW'(SYNC_W - 1) : '0;
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the registered state, counter and shifter only.
    always_comb begin
        dout     = IDLE_BIT;
        last_bit = 1'b0;
        case (state)
            ST_SYNC: dout = PAT_EXT[cnt];
            ST_DATA: begin
                dout = shift_msb;
`ifndef SEQ_TX_PARITY_EN
                last_bit = (cnt == '0);
`endif
            end
            ST_PAR: begin
`ifdef SEQ_TX_PARITY_EN
                dout     = parity;
                last_bit = 1'b1;
`endif
            end
            default: dout = IDLE_BIT;
        endcase
        busy       = (state != ST_IDLE);
        dout_valid = busy;
        frame_done = last_bit;
        load_ready = (state == ST_IDLE) | last_bit;
    end

endmodule : seq_1011_tx
`default_nettype wire
